// File: rtl/rx_fifo_pkg.sv
// Shared definitions for the RX FIFO channel: interrupt FSM states,
// interrupt cause codes and the default timeout counter width.
package rx_fifo_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        ARMED       = 2'd1,
        IRQ_LEVEL   = 2'd2,
        IRQ_TIMEOUT = 2'd3
    } irq_state_t;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_LEVEL   = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    localparam int TW_DEFAULT = 21;

endpackage

// File: rtl/rx_fifo_mem.sv
// DEPTH x DW storage array: synchronous write, asynchronous read, no reset.
// Contents are only ever observed through the show-ahead port while the
// FIFO is non-empty, so uninitialised entries are never visible.
module rx_fifo_mem #(
    parameter int DW    = 8,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] r_mem [DEPTH];

    // Store the incoming word at the write pointer.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = r_mem[rd_addr];

endmodule

// File: rtl/rx_fifo_ch.sv
// Parametrised UART receive FIFO with show-ahead read port, occupancy
// level, sticky overflow, and a held level/timeout interrupt with cause.
module rx_fifo_ch
    import rx_fifo_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH),
    parameter int TW    = TW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] din,
    input  logic          wr_en,
    input  logic          rx_busy,
    output logic          rx_finish,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [AW:0]   level,
    output logic          full,
    output logic          empty,
    output logic          full_busy,
    output logic          overflow,
    input  logic          ovf_clr,
    input  logic [AW:0]   thresh,
    input  logic [TW-1:0] timeout_limit,
    input  logic          irq_clr,
    output logic          fifo_interrupt,
    output logic [1:0]    irq_cause
);

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;
    logic          r_rx_finish;
    logic          r_overflow;
    logic [TW-1:0] r_tcnt;
    irq_state_t    r_state;
    irq_state_t    w_state_next;

    logic          w_full;
    logic          w_empty;
    logic          w_wr_acc;
    logic          w_rd_fire;
    logic [AW:0]   w_level_next;

    assign w_full    = (r_level == DEPTH_L);
    assign w_empty   = (r_level == '0);
    // Full is judged on registered state, so a same-edge read never frees room.
    assign w_wr_acc  = wr_en & ~w_full;
    assign w_rd_fire = ~w_empty & rd_ready;

    rx_fifo_mem #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (w_wr_acc),
        .wr_addr (r_wr_ptr),
        .wr_data (din),
        .rd_addr (r_rd_ptr),
        .rd_data (rd_data)
    );

    // Occupancy after this edge; a simultaneous write and read cancel out.
    always_comb begin
        w_level_next = r_level;
        if (w_wr_acc && !w_rd_fire) begin
            w_level_next = r_level + 1'b1;
        end else if (!w_wr_acc && w_rd_fire) begin
            w_level_next = r_level - 1'b1;
        end
    end

    // Pointers and level; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr_acc)  r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_fire) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_level <= w_level_next;
        end
    end

    // Write acknowledge and sticky overflow; a drop beats a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_finish <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_rx_finish <= wr_en;
            if (wr_en && w_full) begin
                r_overflow <= 1'b1;
            end else if (ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // Idle counter: runs only while ARMED with no traffic, saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tcnt <= '0;
        end else if (r_state != ARMED || w_wr_acc || w_rd_fire) begin
            r_tcnt <= '0;
        end else if (r_tcnt != '1) begin
            r_tcnt <= r_tcnt + 1'b1;
        end
    end

    // Interrupt FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Interrupt FSM next state and Moore output decode.
    always_comb begin
        w_state_next   = r_state;
        fifo_interrupt = 1'b0;
        irq_cause      = CAUSE_NONE;
        case (r_state)
            IDLE: begin
                if (w_wr_acc) w_state_next = ARMED;
            end
            ARMED: begin
                if (thresh != '0 && w_level_next >= thresh) begin
                    w_state_next = IRQ_LEVEL;
                end else if (timeout_limit != '0 && r_tcnt >= timeout_limit && !w_empty) begin
                    w_state_next = IRQ_TIMEOUT;
                end else if (w_level_next == '0) begin
                    w_state_next = IDLE;
                end
            end
            IRQ_LEVEL, IRQ_TIMEOUT: begin
                fifo_interrupt = 1'b1;
                irq_cause      = (r_state == IRQ_LEVEL) ? CAUSE_LEVEL : CAUSE_TIMEOUT;
                // A clear always lands in ARMED/IDLE; any pending condition
                // is picked up again from ARMED on the following cycle.
                if (irq_clr) begin
                    w_state_next = (w_level_next != '0) ? ARMED : IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign rx_finish = r_rx_finish;
    assign rd_valid  = ~w_empty;
    assign level     = r_level;
    assign full      = w_full;
    assign empty     = w_empty;
    assign full_busy = w_full & rx_busy;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_rx_fifo_ch.sv
// Directed self-checking bench for rx_fifo_ch with a data scoreboard queue.
module tb_rx_fifo_ch;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int TW    = 21;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] din;
    logic          wr_en;
    logic          rx_busy;
    logic          rx_finish;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [AW:0]   level;
    logic          full;
    logic          empty;
    logic          full_busy;
    logic          overflow;
    logic          ovf_clr;
    logic [AW:0]   thresh;
    logic [TW-1:0] timeout_limit;
    logic          irq_clr;
    logic          fifo_interrupt;
    logic [1:0]    irq_cause;

    int n_checks = 0;
    int n_fail   = 0;
    int m_level  = 0;
    logic [DW-1:0] q [$];

    always #5 clk = ~clk;

    rx_fifo_ch #(.DW(DW), .DEPTH(DEPTH), .TW(TW)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .wr_en(wr_en), .rx_busy(rx_busy),
        .rx_finish(rx_finish), .rd_data(rd_data), .rd_valid(rd_valid),
        .rd_ready(rd_ready), .level(level), .full(full), .empty(empty),
        .full_busy(full_busy), .overflow(overflow), .ovf_clr(ovf_clr),
        .thresh(thresh), .timeout_limit(timeout_limit), .irq_clr(irq_clr),
        .fifo_interrupt(fifo_interrupt), .irq_cause(irq_cause)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [DW-1:0] d);
        @(negedge clk);
        din = d; wr_en = 1'b1;
        @(posedge clk); #1;
        wr_en = 1'b0;
        if (m_level < DEPTH) begin
            q.push_back(d);
            m_level++;
        end
        $display("write %02h -> level %0d overflow %0b", d, level, overflow);
        check("wr_level", 32'(level), 32'(m_level));
        check("rx_finish", 32'(rx_finish), 32'd1);
    endtask

    task automatic do_read();
        logic [DW-1:0] exp_d;
        @(negedge clk);
        exp_d = q.pop_front();
        check("rd_valid", 32'(rd_valid), 32'd1);
        check("rd_data", 32'(rd_data), 32'(exp_d));
        $display("read %02h (expected %02h)", rd_data, exp_d);
        rd_ready = 1'b1;
        @(posedge clk); #1;
        rd_ready = 1'b0;
        m_level--;
        check("rd_level", 32'(level), 32'(m_level));
    endtask

    // Write and read on the same edge; the write is judged on pre-edge fullness.
    task automatic do_wr_rd(input logic [DW-1:0] d);
        logic [DW-1:0] exp_d;
        logic          acc;
        @(negedge clk);
        acc   = (m_level < DEPTH);
        exp_d = q.pop_front();
        check("wrrd_valid", 32'(rd_valid), 32'd1);
        check("wrrd_data", 32'(rd_data), 32'(exp_d));
        din = d; wr_en = 1'b1; rd_ready = 1'b1;
        @(posedge clk); #1;
        wr_en = 1'b0; rd_ready = 1'b0;
        if (acc) q.push_back(d);
        m_level = m_level - 1 + (acc ? 1 : 0);
        $display("write %02h + read %02h -> level %0d", d, exp_d, level);
        check("wrrd_level", 32'(level), 32'(m_level));
    endtask

    task automatic pulse_ovf_clr();
        @(negedge clk); ovf_clr = 1'b1;
        @(posedge clk); #1; ovf_clr = 1'b0;
        check("ovf_clr", 32'(overflow), 32'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int k;
        rst_n = 1'b0; din = '0; wr_en = 1'b0; rx_busy = 1'b0; rd_ready = 1'b0;
        ovf_clr = 1'b0; thresh = '0; timeout_limit = '0; irq_clr = 1'b0;
        #12;
        check("rst_valid", 32'(rd_valid), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_irq", 32'(fifo_interrupt), 32'd0);
        check("rst_cause", 32'(irq_cause), 32'd0);
        check("rst_finish", 32'(rx_finish), 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // Fill to DEPTH, overflow, drain
        for (int i = 0; i < DEPTH; i++) do_write(8'hA0 + 8'(i));
        check("full", 32'(full), 32'd1);
        rx_busy = 1'b1; #1;
        check("full_busy", 32'(full_busy), 32'd1);
        rx_busy = 1'b0;
        check("ovf_before", 32'(overflow), 32'd0);
        do_write(8'hEE);
        check("ovf_set", 32'(overflow), 32'd1);
        idle(1);
        check("finish_drop", 32'(rx_finish), 32'd0);
        pulse_ovf_clr();
        for (int i = 0; i < DEPTH; i++) do_read();
        check("drain_empty", 32'(empty), 32'd1);

        // Pointer wrap
        for (int i = 0; i < 5; i++) do_write(8'h50 + 8'(i));
        for (int i = 0; i < 5; i++) do_read();
        for (int i = 0; i < 7; i++) do_write(8'h10 + 8'(i));
        for (int i = 0; i < 7; i++) do_read();
        check("wrap_ovf", 32'(overflow), 32'd0);

        // Simultaneous write and read at DEPTH-1 and at DEPTH
        for (int i = 0; i < 7; i++) do_write(8'h30 + 8'(i));
        do_wr_rd(8'h37);
        do_write(8'h38);
        check("sim_full", 32'(full), 32'd1);
        do_wr_rd(8'h39);
        check("sim_ovf", 32'(overflow), 32'd1);
        while (m_level > 0) do_read();
        pulse_ovf_clr();
        idle(2);

        // Level interrupt
        thresh = 5;
        for (int i = 0; i < 4; i++) do_write(8'h60 + 8'(i));
        check("lvl_pre", 32'(fifo_interrupt), 32'd0);
        do_write(8'h64);
        check("lvl_irq", 32'(fifo_interrupt), 32'd1);
        check("lvl_cause", 32'(irq_cause), 32'd1);
        idle(10);
        check("lvl_hold", 32'(fifo_interrupt), 32'd1);
        @(negedge clk); irq_clr = 1'b1;
        @(posedge clk); #1; irq_clr = 1'b0;
        check("lvl_clr", 32'(fifo_interrupt), 32'd0);
        idle(1);
        check("lvl_refire", 32'(fifo_interrupt), 32'd1);
        check("lvl_refire_cause", 32'(irq_cause), 32'd1);
        @(negedge clk); thresh = 0; irq_clr = 1'b1;
        @(posedge clk); #1; irq_clr = 1'b0;
        while (m_level > 0) do_read();
        idle(2);
        check("lvl_done", 32'(fifo_interrupt), 32'd0);

        // Timeout interrupt and restart by a read
        timeout_limit = 20;
        do_write(8'h71);
        k = 0;
        while (k < 40 && fifo_interrupt !== 1'b1) begin idle(1); k++; end
        $display("timeout irq after %0d cycles", k);
        check("to_latency", 32'(k >= 19 && k <= 22), 32'd1);
        check("to_cause", 32'(irq_cause), 32'd2);
        do_write(8'h72);
        do_write(8'h73);
        @(negedge clk); irq_clr = 1'b1;
        @(posedge clk); #1; irq_clr = 1'b0;
        check("to_clr", 32'(fifo_interrupt), 32'd0);
        idle(10);
        check("to_quiet", 32'(fifo_interrupt), 32'd0);
        do_read();
        k = 0;
        while (k < 40 && fifo_interrupt !== 1'b1) begin idle(1); k++; end
        $display("timeout irq %0d cycles after read", k);
        check("to_restart", 32'(k >= 19 && k <= 22), 32'd1);
        check("to_cause2", 32'(irq_cause), 32'd2);

        // Asynchronous reset with 3 words and an interrupt pending
        do_write(8'h74);
        check("pre_rst_level", 32'(level), 32'd3);
        @(negedge clk); #2;
        rst_n = 1'b0; #1;
        check("arst_valid", 32'(rd_valid), 32'd0);
        check("arst_level", 32'(level), 32'd0);
        check("arst_irq", 32'(fifo_interrupt), 32'd0);
        check("arst_cause", 32'(irq_cause), 32'd0);
        check("arst_empty", 32'(empty), 32'd1);
        q.delete(); m_level = 0;
        timeout_limit = 0;
        @(negedge clk); rst_n = 1'b1;
        idle(1);
        check("post_rst_valid", 32'(rd_valid), 32'd0);
        do_write(8'hAB);
        do_read();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
